// File: rtl/bcd_display_driver.sv
// bcd_display_driver: shows a 32-bit value on NDIGITS 7-seg digits as decimal (double-dabble) or raw hex
module bcd_display_driver #(
   parameter int NDIGITS  = 8,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          display,
   input  logic                 hex_mode,
   output logic [7*NDIGITS-1:0] segs,
   output logic                 busy,
   output logic                 overflow
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   state_t state;
   logic [31:0] shadow_val, shift_reg;
   logic shadow_mode, shadow_valid, start, ovf_next, seen;
   logic [39:0] bcd, bcd_adj;
   logic [4:0] bit_cnt;
   logic [3:0] nib;
   logic [7*NDIGITS-1:0] segs_next;
   assign start = !shadow_valid || display != shadow_val || hex_mode != shadow_mode;
   // add-3 correction on every BCD digit ahead of the shift
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 10; i++)
         bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
   end
   // digit pick, leading-zero blanking and overflow dash pattern
   always_comb begin
      seen = 1'b0;
      nib = 4'd0;
      segs_next = '0;
      ovf_next = !shadow_mode && (|bcd[39:4*NDIGITS]);
      for (int i = NDIGITS - 1; i >= 0; i--) begin
         nib = shadow_mode ? shadow_val[4*i +: 4] : bcd[4*i +: 4];
         seen = seen || (nib != 4'd0) || (i == 0);
         segs_next[7*i +: 7] = ovf_next ? 7'h3F : (BLANK_LZ && !seen) ? 7'h7F : SEG[nib];
      end
   end
   // conversion FSM; busy, segs and overflow are all registered here
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         busy         <= 1'b0;
         overflow     <= 1'b0;
         segs         <= {NDIGITS{7'h7F}};
         shadow_valid <= 1'b0;
         shadow_mode  <= 1'b0;
         shadow_val   <= '0;
         shift_reg    <= '0;
         bcd          <= '0;
         bit_cnt      <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               shadow_val  <= display;
               shadow_mode <= hex_mode;
               shift_reg   <= display;
               bcd         <= '0;
               bit_cnt     <= '0;
               busy        <= 1'b1;
               state       <= hex_mode ? DONE : SHIFT;
            end
            SHIFT: begin
               {bcd, shift_reg} <= {bcd_adj, shift_reg} << 1;
               bit_cnt <= bit_cnt + 5'd1;
               if (bit_cnt == 5'd31) state <= DONE;
            end
            DONE: begin
               segs         <= segs_next;
               overflow     <= ovf_next;
               shadow_valid <= 1'b1;
               busy         <= 1'b0;
               state        <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bcd_display_driver.sv
// tb_bcd_display_driver: directed vectors with hand-computed digit patterns
module tb_bcd_display_driver;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [31:0] display = '0;
   logic hex_mode = 1'b0;
   logic [55:0] segs;
   logic busy, overflow;
   int n_cmp = 0;
   int n_err = 0;
   int cnt, glitch;
   localparam logic [6:0] B = 7'h7F;
   localparam logic [55:0] S_BLANK = {8{B}};
   localparam logic [55:0] S_0     = {{7{B}}, 7'h40};
   localparam logic [55:0] S_1234  = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
   localparam logic [55:0] S_9S    = {8{7'h10}};
   localparam logic [55:0] S_DASH  = {8{7'h3F}};
   localparam logic [55:0] S_5     = {{7{B}}, 7'h12};
   localparam logic [55:0] S_7     = {{7{B}}, 7'h78};
   localparam logic [55:0] S_DEAD  = {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E};
   localparam logic [55:0] S_A0    = {{6{B}}, 7'h08, 7'h40};
   localparam logic [55:0] S_160   = {{5{B}}, 7'h79, 7'h02, 7'h40};
   localparam logic [55:0] S_42    = {{6{B}}, 7'h19, 7'h24};

   bcd_display_driver dut (
      .clk(clk), .rst(rst), .display(display), .hex_mode(hex_mode),
      .segs(segs), .busy(busy), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // called just after the start edge; counts busy cycles and segs changes while busy
   task automatic run(output int c, output int g);
      logic [55:0] prev;
      prev = segs;
      c = 0;
      g = 0;
      while (busy && c < 200) begin
         c++;
         tick();
         if (busy && segs !== prev) g++;
      end
   endtask

   task automatic convert(input logic [31:0] v, input logic h, output int c, output int g);
      display = v;
      hex_mode = h;
      tick();
      run(c, g);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tick();
      check("rst_busy", busy, 1'b0);
      check("rst_segs", segs, S_BLANK);
      check("rst_ovf", overflow, 1'b0);
      tick();
      rst = 1'b0;
      tick();
      run(cnt, glitch);
      check("zero_lat", cnt, 33);
      check("zero_segs", segs, S_0);
      check("zero_ovf", overflow, 1'b0);

      convert(32'd12345678, 1'b0, cnt, glitch);
      check("dec_lat", cnt, 33);
      check("dec_glitch", glitch, 0);
      check("dec_segs", segs, S_1234);
      check("dec_ovf", overflow, 1'b0);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (busy) cnt++;
      end
      check("hold_busy", cnt, 0);

      convert(32'd99999999, 1'b0, cnt, glitch);
      check("max_lat", cnt, 33);
      check("max_segs", segs, S_9S);
      check("max_ovf", overflow, 1'b0);
      convert(32'd100000000, 1'b0, cnt, glitch);
      check("ovf_segs", segs, S_DASH);
      check("ovf_flag", overflow, 1'b1);

      display = 32'd5;
      tick();
      cnt = 0;
      while (busy && cnt < 200) begin
         cnt++;
         if (cnt == 9) display = 32'd7;
         tick();
      end
      check("chg_lat", cnt, 33);
      check("chg_first", segs, S_5);
      tick();
      check("chg_restart", busy, 1'b1);
      run(cnt, glitch);
      check("chg_lat2", cnt, 33);
      check("chg_glitch", glitch, 0);
      check("chg_second", segs, S_7);

      convert(32'hDEADBEEF, 1'b1, cnt, glitch);
      check("hex_lat", cnt, 1);
      check("hex_segs", segs, S_DEAD);
      check("hex_ovf", overflow, 1'b0);
      convert(32'h000000A0, 1'b1, cnt, glitch);
      check("hexa0_segs", segs, S_A0);
      convert(32'h000000A0, 1'b0, cnt, glitch);
      check("mode_lat", cnt, 33);
      check("mode_segs", segs, S_160);

      display = 32'd42;
      tick();
      repeat (16) tick();
      check("mid_busy", busy, 1'b1);
      rst = 1'b1;
      tick();
      check("abort_busy", busy, 1'b0);
      check("abort_segs", segs, S_BLANK);
      check("abort_ovf", overflow, 1'b0);
      rst = 1'b0;
      tick();
      run(cnt, glitch);
      check("reconv_lat", cnt, 33);
      check("reconv_segs", segs, S_42);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
